// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: registered multi-mode LED pattern generator for the icestick LEDs
module led_pattern_sequencer #(
   parameter int CLK_HZ    = 12000000,
   parameter int STEP_DIV  = 1200000,
   parameter int PWM_BITS  = 8,
   parameter int DUTY_STEP = 17
) (
   input  logic       CLK_IN,
   input  logic       RST_N,
   input  logic [1:0] MODE_IN,
   input  logic       PAUSE_IN,
   output logic       GLED5,
   output logic       RLED1,
   output logic       RLED2,
   output logic       RLED3,
   output logic       RLED4
);
   localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [PWM_BITS-1:0] DUTY_INC = PWM_BITS'(DUTY_STEP);
   localparam logic [1:0] M_BINARY  = 2'd0;
   localparam logic [1:0] M_CHASE   = 2'd1;
   localparam logic [1:0] M_BOUNCE  = 2'd2;
   localparam logic [1:0] M_BREATHE = 2'd3;
   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;
   if (STEP_DIV < 2 || CLK_HZ < 1 || DUTY_STEP < 1 || ((2 ** PWM_BITS) - 1) % DUTY_STEP != 0) begin : g_bad_param
      $error("led_pattern_sequencer: invalid STEP_DIV/CLK_HZ/DUTY_STEP");
   end
   logic [1:0] mode_m, mode_s, cur_mode, mode_n;
   logic pause_m, pause_s;
   logic [DW-1:0] div_cnt;
   logic step_tick;
   logic [3:0] pos, pos_n;
   logic dir, dir_n, tog, tog_n;
   logic [PWM_BITS-1:0] duty, duty_n, pwm_cnt;
   logic [3:0] red, red_n;
   logic grn, grn_n;
   assign step_tick = (div_cnt == DIV_LAST) && !pause_s;
   // Input synchronisers, step prescaler (frozen by pause) and free-running PWM counter.
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         mode_m  <= '0;
         mode_s  <= '0;
         pause_m <= 1'b0;
         pause_s <= 1'b0;
         div_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         mode_m  <= MODE_IN;
         mode_s  <= mode_m;
         pause_m <= PAUSE_IN;
         pause_s <= pause_m;
         if (!pause_s) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end
   // Pattern next-state: a mode change on a tick restarts the new mode instead of stepping the old one.
   always_comb begin
      mode_n = cur_mode;
      pos_n  = pos;
      dir_n  = dir;
      duty_n = duty;
      tog_n  = tog;
      if (step_tick && mode_s != cur_mode) begin
         mode_n = mode_s;
         pos_n  = '0;
         dir_n  = UP;
         duty_n = '0;
         tog_n  = 1'b0;
      end else if (step_tick) begin
         case (cur_mode)
            M_BINARY: begin
               pos_n = pos + 4'd1;
               tog_n = (pos == 4'd15) ? ~tog : tog;
            end
            M_CHASE: pos_n = (pos == 4'd3) ? 4'd0 : pos + 4'd1;
            M_BOUNCE: begin
               dir_n = (dir == UP) ? ((pos == 4'd3) ? DOWN : UP) : ((pos == 4'd0) ? UP : DOWN);
               pos_n = (dir_n == UP) ? pos + 4'd1 : pos - 4'd1;
            end
            default: begin
               dir_n  = (dir == UP) ? ((duty == DUTY_MAX) ? DOWN : UP) : ((duty == '0) ? UP : DOWN);
               duty_n = (dir_n == UP) ? duty + DUTY_INC : duty - DUTY_INC;
            end
         endcase
      end
   end
   assign red_n = (mode_n == M_BREATHE) ? {4{pwm_cnt < duty_n}} :
                  (mode_n == M_BINARY)  ? pos_n : 4'b0001 << pos_n[1:0];
   assign grn_n = (mode_n == M_BINARY) ? tog_n :
                  (mode_n == M_CHASE)  ? (pos_n == 4'd3) :
                  (mode_n == M_BOUNCE) ? (pos_n == 4'd0 || pos_n == 4'd3) : 1'b1;
   // Pattern state and registered LED drivers, both loaded from next-state so LEDs follow a tick by one cycle.
   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         cur_mode <= M_BINARY;
         pos      <= '0;
         dir      <= UP;
         duty     <= '0;
         tog      <= 1'b0;
         red      <= '0;
         grn      <= 1'b0;
      end else begin
         cur_mode <= mode_n;
         pos      <= pos_n;
         dir      <= dir_n;
         duty     <= duty_n;
         tog      <= tog_n;
         red      <= red_n;
         grn      <= grn_n;
      end
   end
   assign GLED5 = grn;
   assign RLED1 = red[0];
   assign RLED2 = red[1];
   assign RLED3 = red[2];
   assign RLED4 = red[3];
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed vector bench for led_pattern_sequencer (STEP_DIV=4, PWM_BITS=4, DUTY_STEP=5)
module tb_led_pattern_sequencer;
   typedef struct {
      logic [1:0] mode;
      int         cyc;
      logic [3:0] r;
      logic       g;
   } vec_t;
   logic CLK_IN = 1'b0;
   logic RST_N = 1'b0;
   logic [1:0] MODE_IN = 2'd0;
   logic PAUSE_IN = 1'b0;
   logic GLED5, RLED1, RLED2, RLED3, RLED4;
   int errors = 0;
   int checks = 0;
   vec_t vecs[$];
   int exp_duty[7] = '{0, 5, 10, 15, 10, 5, 0};
   int cnt[4];
   led_pattern_sequencer #(.STEP_DIV(4), .PWM_BITS(4), .DUTY_STEP(5)) dut (
      .CLK_IN(CLK_IN), .RST_N(RST_N), .MODE_IN(MODE_IN), .PAUSE_IN(PAUSE_IN),
      .GLED5(GLED5), .RLED1(RLED1), .RLED2(RLED2), .RLED3(RLED3), .RLED4(RLED4)
   );
   always #5 CLK_IN = ~CLK_IN;
   task automatic step(input int n);
      repeat (n) @(posedge CLK_IN);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] leds();
      return {27'd0, GLED5, RLED4, RLED3, RLED2, RLED1};
   endfunction
   task automatic run_vecs(input int lo, input int hi, input string tag);
      for (int i = lo; i < hi; i++) begin
         MODE_IN = vecs[i].mode;
         step(vecs[i].cyc);
         chk($sformatf("%s[%0d]", tag, i), leds(), {27'd0, vecs[i].g, vecs[i].r});
      end
   endtask
   initial begin
      vecs.push_back('{2'd0, 3,  4'b0000, 1'b0});
      vecs.push_back('{2'd0, 1,  4'b0001, 1'b0});
      vecs.push_back('{2'd0, 4,  4'b0010, 1'b0});
      vecs.push_back('{2'd0, 52, 4'b1111, 1'b0});
      vecs.push_back('{2'd0, 4,  4'b0000, 1'b1});
      vecs.push_back('{2'd0, 4,  4'b0001, 1'b1});
      vecs.push_back('{2'd1, 3,  4'b0001, 1'b1});
      vecs.push_back('{2'd1, 1,  4'b0001, 1'b0});
      vecs.push_back('{2'd1, 4,  4'b0010, 1'b0});
      vecs.push_back('{2'd1, 4,  4'b0100, 1'b0});
      vecs.push_back('{2'd1, 4,  4'b1000, 1'b1});
      vecs.push_back('{2'd1, 4,  4'b0001, 1'b0});
      vecs.push_back('{2'd1, 4,  4'b0010, 1'b0});
      vecs.push_back('{2'd2, 4,  4'b0001, 1'b1});
      vecs.push_back('{2'd2, 4,  4'b0010, 1'b0});
      vecs.push_back('{2'd2, 4,  4'b0100, 1'b0});
      vecs.push_back('{2'd2, 4,  4'b1000, 1'b1});
      vecs.push_back('{2'd2, 4,  4'b0100, 1'b0});
      vecs.push_back('{2'd2, 4,  4'b0010, 1'b0});
      vecs.push_back('{2'd2, 4,  4'b0001, 1'b1});
      vecs.push_back('{2'd2, 4,  4'b0010, 1'b0});
      // reset held for three edges
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk($sformatf("reset[%0d]", i), leds(), 32'd0);
      end
      RST_N = 1'b1;
      // BINARY count and wrap, then CHASE entry
      run_vecs(0, 13, "bin_chase");
      // pause at CHASE pos=1; the tick that would land just as pause syncs in is suppressed
      step(1);
      chk("pause_pre", leds(), 32'b00010);
      PAUSE_IN = 1'b1;
      for (int i = 0; i < 22; i++) begin
         step(1);
         chk($sformatf("pause_hold[%0d]", i), leds(), 32'b00010);
      end
      PAUSE_IN = 1'b0;
      step(2);
      chk("pause_rel_wait", leds(), 32'b00010);
      step(1);
      chk("pause_rel_tick", leds(), 32'b00100);
      step(4);
      chk("pause_next", leds(), 32'b11000);
      // BOUNCE direction
      run_vecs(13, 21, "bounce");
      // BREATHE: pause each duty level and count PWM high cycles over a 16-cycle window
      MODE_IN = 2'd3;
      step(4);
      for (int d = 0; d < 7; d++) begin
         PAUSE_IN = 1'b1;
         step(3);
         for (int k = 0; k < 4; k++) cnt[k] = 0;
         for (int c = 0; c < 16; c++) begin
            step(1);
            cnt[0] += int'(RLED1);
            cnt[1] += int'(RLED2);
            cnt[2] += int'(RLED3);
            cnt[3] += int'(RLED4);
         end
         chk($sformatf("breathe_g[%0d]", d), {31'd0, GLED5}, 32'd1);
         for (int k = 0; k < 4; k++)
            chk($sformatf("breathe_duty[%0d].led%0d", d, k + 1), cnt[k], exp_duty[d]);
         if (d < 6) begin
            PAUSE_IN = 1'b0;
            step(4);
         end
      end
      // one-cycle reset in BREATHE while paused
      RST_N = 1'b0;
      step(1);
      chk("rst_mid_out", leds(), 32'd0);
      chk("rst_mid_mode", {30'd0, dut.cur_mode}, 32'd0);
      chk("rst_mid_div", {30'd0, dut.div_cnt}, 32'd0);
      RST_N = 1'b1;
      PAUSE_IN = 1'b0;
      MODE_IN = 2'd0;
      step(3);
      chk("rst_mid_pre_tick", leds(), 32'd0);
      step(1);
      chk("rst_mid_first_tick", leds(), 32'b00001);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
